// File: rtl/ram_block_copy.sv
`default_nettype none
// ============================================================================
//  Module      : ram_block_copy
//  Description : DMA-style block copier for a 64x8 dual-port synchronous RAM.
//                Port A reads the source, port B writes the destination, one
//                byte per cycle after a two-cycle pipeline fill.
//                Optional macro RAM_BLOCK_COPY_OVERLAP_EN: forward-overlapping
//                requests run as a descending copy instead of being rejected.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_block_copy #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] ram_adrs_a,
  output logic          ram_we_a,
  input  logic [DW-1:0] ram_q_a,
  output logic [AW-1:0] ram_adrs_b,
  output logic          ram_we_b,
  output logic [DW-1:0] ram_d_b
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FIN    = 2'd3;

  // Largest legal byte count: the whole RAM.
  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

  logic [1:0]    state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;          // writes still to be issued
  logic [AW-1:0] adrs_a_q, adrs_a_d;
  logic [AW-1:0] adrs_b_q, adrs_b_d;
  logic          we_b_q, we_b_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          desc_q, desc_d;        // copy runs from the top address down

  logic [AW-1:0] addr_diff;
  logic [AW-1:0] len_m1;
  logic [AW-1:0] first_src;
  logic [AW-1:0] first_dst;
  logic [AW-1:0] step;
  logic          len_bad;
  logic          fwd_overlap;
  logic          req_reject;
  logic          req_desc;

  // Decode the incoming request: legality, overlap direction and start addresses.
  always_comb begin
    addr_diff   = dst_addr - src_addr;
    len_m1      = len[AW-1:0] - AW'(1);
    len_bad     = (len == '0) || (len > MAX_LEN);
    // Destination starts inside the not-yet-read part of the source window.
    fwd_overlap = (addr_diff != '0) && ({1'b0, addr_diff} < len);
`ifdef RAM_BLOCK_COPY_OVERLAP_EN
    req_reject  = len_bad;
    req_desc    = fwd_overlap;
`else
    req_reject  = len_bad || fwd_overlap;
    req_desc    = 1'b0;
`endif
    first_src   = req_desc ? (src_addr + len_m1) : src_addr;
    first_dst   = req_desc ? (dst_addr + len_m1) : dst_addr;
    step        = desc_q ? {AW{1'b1}} : AW'(1);
  end

  // State and registered outputs; reset aborts a copy on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      adrs_a_q <= '0;
      adrs_b_q <= '0;
      we_b_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      desc_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adrs_a_q <= adrs_a_d;
      adrs_b_q <= adrs_b_d;
      we_b_q   <= we_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      desc_q   <= desc_d;
    end
  end

  // Next-state sequencing: IDLE -> FILL -> STREAM (len cycles) -> FIN -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start && !req_reject) state_d = S_FILL;
      S_FILL:   state_d = S_STREAM;
      S_STREAM: if (cnt_q == (AW+1)'(1)) state_d = S_FIN;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and address datapath for the cycle after the coming edge.
  always_comb begin
    cnt_d    = cnt_q;
    adrs_a_d = adrs_a_q;
    adrs_b_d = adrs_b_q;
    we_b_d   = we_b_q;
    busy_d   = busy_q;
    desc_d   = desc_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (req_reject) begin
            err_d = 1'b1;
          end else begin
            busy_d   = 1'b1;
            cnt_d    = len;
            desc_d   = req_desc;
            adrs_a_d = first_src;
            adrs_b_d = first_dst;   // parked until the first write
          end
        end
      end
      S_FILL: begin
        // First read is in flight; the first write goes out next cycle.
        we_b_d = 1'b1;
        if (cnt_q > (AW+1)'(1)) adrs_a_d = adrs_a_q + step;
      end
      S_STREAM: begin
        cnt_d    = cnt_q - (AW+1)'(1);
        adrs_b_d = adrs_b_q + step;
        // Reads lead writes by one, so stop advancing two before the end.
        if (cnt_q > (AW+1)'(2)) adrs_a_d = adrs_a_q + step;
        if (cnt_q == (AW+1)'(1)) begin
          we_b_d = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: begin
        // FIN: the done pulse is showing; any start here is ignored.
      end
    endcase
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign ram_adrs_a = adrs_a_q;
  assign ram_we_a   = 1'b0;
  assign ram_adrs_b = adrs_b_q;
  assign ram_we_b   = we_b_q;
  assign ram_d_b    = ram_q_a;

endmodule
`default_nettype wire

// File: tb/tb_ram_block_copy.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_block_copy
//  Description : Self-checking bench for ram_block_copy with a 64x8 RAM model.
//                Cycle n below is the n-th clock period after the edge that
//                samples start; outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_block_copy;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] src_addr = '0;
  logic [5:0] dst_addr = '0;
  logic [6:0] len = '0;
  logic       busy, done, err;
  logic [5:0] ram_adrs_a, ram_adrs_b;
  logic       ram_we_a, ram_we_b;
  logic [7:0] ram_q_a, ram_d_b;

  int checks = 0;
  int failures = 0;

  // RAM model plus a bench-side write port for preloading
  logic [7:0] mem [64];
  logic       tb_we = 1'b0;
  logic [5:0] tb_addr = '0;
  logic [7:0] tb_data = '0;
  logic       we_a_seen = 1'b0;

  always #5 clk = ~clk;

  ram_block_copy #(.AW(6), .DW(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .ram_adrs_a(ram_adrs_a), .ram_we_a(ram_we_a), .ram_q_a(ram_q_a),
    .ram_adrs_b(ram_adrs_b), .ram_we_b(ram_we_b), .ram_d_b(ram_d_b)
  );

  always @(posedge clk) begin
    ram_q_a <= mem[ram_adrs_a];
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (ram_we_b) mem[ram_adrs_b] <= ram_d_b;
  end

  always @(negedge clk) begin
    if (ram_we_a !== 1'b0) we_a_seen <= 1'b1;
  end

  task automatic ram_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  // Present a one-cycle start; returns just after the sampling edge.
  task automatic issue(input logic [5:0] s, input logic [5:0] d, input logic [6:0] l);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = l;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, err, ram_we_b, ram_we_a} !== 5'b0)
      begin failures++; $display("FAIL reset_ctl got=%b exp=00000", {busy, done, err, ram_we_b, ram_we_a}); end
    checks++;
    if ({ram_adrs_a, ram_adrs_b} !== 12'h000)
      begin failures++; $display("FAIL reset_addr got=%h exp=000", {ram_adrs_a, ram_adrs_b}); end
    rst = 1'b0;
  endtask

  task automatic test_basic_copy();
    logic [3:0] exp_ctl;
    for (int i = 0; i < 8; i++) ram_write(6'(i), 8'(8'h10 + i));
    for (int i = 32; i < 40; i++) ram_write(6'(i), 8'h00);
    issue(6'd0, 6'd32, 7'd8);
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      exp_ctl = {(n >= 1 && n <= 9), (n == 10), 1'b0, (n >= 2 && n <= 9)};
      checks++;
      if ({busy, done, err, ram_we_b} !== exp_ctl)
        begin failures++; $display("FAIL basic_ctl n=%0d got=%b exp=%b", n, {busy, done, err, ram_we_b}, exp_ctl); end
      if (n == 1) begin
        checks++;
        if (ram_adrs_a !== 6'd0)
          begin failures++; $display("FAIL basic_fill_adrs_a got=%0d exp=0", ram_adrs_a); end
      end
      if (n >= 2 && n <= 9) begin
        checks++;
        if ({ram_adrs_b, ram_d_b} !== {6'(32 + n - 2), 8'(8'h10 + n - 2)})
          begin failures++; $display("FAIL basic_write n=%0d got=%0d/%h exp=%0d/%h", n, ram_adrs_b, ram_d_b, 32 + n - 2, 8'(8'h10 + n - 2)); end
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[32 + i] !== 8'(8'h10 + i))
        begin failures++; $display("FAIL basic_dst[%0d] got=%h exp=%h", 32 + i, mem[32 + i], 8'(8'h10 + i)); end
      checks++;
      if (mem[i] !== 8'(8'h10 + i))
        begin failures++; $display("FAIL basic_src[%0d] got=%h exp=%h", i, mem[i], 8'(8'h10 + i)); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'hA0; exp_b[1] = 8'hA1; exp_b[2] = 8'hA2;
    ram_write(6'd62, 8'hA0);
    ram_write(6'd63, 8'hA1);
    ram_write(6'd0,  8'hA2);
    issue(6'd62, 6'd10, 7'd3);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, ram_we_b} !== {(n >= 1 && n <= 4), (n == 5), (n >= 2 && n <= 4)})
        begin failures++; $display("FAIL wrap_ctl n=%0d got=%b", n, {busy, done, ram_we_b}); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[10 + i] !== exp_b[i])
        begin failures++; $display("FAIL wrap_dst[%0d] got=%h exp=%h", 10 + i, mem[10 + i], exp_b[i]); end
    end
  endtask

  task automatic test_len_errors();
    logic [6:0] l;
    for (int k = 0; k < 2; k++) begin
      l = (k == 0) ? 7'd0 : 7'd65;
      issue(6'd0, 6'd20, l);
      for (int n = 1; n <= 3; n++) begin
        @(negedge clk);
        checks++;
        if ({busy, done, err, ram_we_b} !== {2'b00, (n == 1), 1'b0})
          begin failures++; $display("FAIL len_err len=%0d n=%0d got=%b", l, n, {busy, done, err, ram_we_b}); end
      end
    end
  endtask

  task automatic test_forward_overlap();
    for (int i = 0; i < 4; i++) ram_write(6'(i), 8'(i + 1));
    ram_write(6'd4, 8'h00);
    ram_write(6'd5, 8'h00);
    issue(6'd0, 6'd2, 7'd4);
`ifdef RAM_BLOCK_COPY_OVERLAP_EN
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, err, ram_we_b} !== {(n <= 5), (n == 6), 1'b0, (n >= 2 && n <= 5)})
        begin failures++; $display("FAIL ovl_ctl n=%0d got=%b", n, {busy, done, err, ram_we_b}); end
      if (n == 2) begin
        checks++;
        if ({ram_adrs_b, ram_d_b} !== {6'd5, 8'd4})
          begin failures++; $display("FAIL ovl_first_write got=%0d/%h exp=5/04", ram_adrs_b, ram_d_b); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[2 + i] !== 8'(i + 1))
        begin failures++; $display("FAIL ovl_dst[%0d] got=%h exp=%h", 2 + i, mem[2 + i], 8'(i + 1)); end
    end
`else
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, err, ram_we_b} !== {2'b00, (n == 1), 1'b0})
        begin failures++; $display("FAIL ovl_reject n=%0d got=%b", n, {busy, done, err, ram_we_b}); end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mem[i] !== ((i < 4) ? 8'(i + 1) : 8'h00))
        begin failures++; $display("FAIL ovl_unchanged[%0d] got=%h", i, mem[i]); end
    end
`endif
  endtask

  task automatic test_reset_mid_copy();
    for (int i = 0; i < 16; i++) ram_write(6'(i), 8'(8'h30 + i));
    for (int i = 40; i < 56; i++) ram_write(6'(i), 8'hEE);
    issue(6'd0, 6'd40, 7'd16);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      checks++;
      if ({busy, ram_we_b} !== {1'b1, (n >= 2)})
        begin failures++; $display("FAIL mid_pre n=%0d got=%b", n, {busy, ram_we_b}); end
    end
    // Reset lands on the edge that commits the third write (address 42).
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int m = 1; m <= 4; m++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, err, ram_we_b} !== 4'b0000)
        begin failures++; $display("FAIL mid_post m=%0d got=%b exp=0000", m, {busy, done, err, ram_we_b}); end
    end
    checks++;
    if ({ram_adrs_a, ram_adrs_b} !== 12'h000)
      begin failures++; $display("FAIL mid_addr got=%h exp=000", {ram_adrs_a, ram_adrs_b}); end
    for (int i = 40; i < 56; i++) begin
      checks++;
      if (mem[i] !== ((i < 43) ? 8'(8'h30 + i - 40) : 8'hEE))
        begin failures++; $display("FAIL mid_mem[%0d] got=%h", i, mem[i]); end
    end
  endtask

  task automatic test_start_held();
    ram_write(6'd20, 8'h55);
    ram_write(6'd21, 8'h66);
    ram_write(6'd30, 8'h00);
    ram_write(6'd31, 8'h00);
    @(negedge clk);
    start = 1'b1; src_addr = 6'd20; dst_addr = 6'd30; len = 7'd2;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 6) start = 1'b0;   // second copy was accepted at edge T+5
      checks++;
      if ({busy, done, err, ram_we_b} !==
          {(n <= 3 || (n >= 6 && n <= 8)), (n == 4 || n == 9), 1'b0, (n == 2 || n == 3 || n == 7 || n == 8)})
        begin failures++; $display("FAIL held_ctl n=%0d got=%b", n, {busy, done, err, ram_we_b}); end
    end
    checks++;
    if ({mem[30], mem[31]} !== 16'h5566)
      begin failures++; $display("FAIL held_dst got=%h exp=5566", {mem[30], mem[31]}); end
  endtask

  task automatic test_we_a_tied();
    checks++;
    if (we_a_seen !== 1'b0)
      begin failures++; $display("FAIL we_a_tied got=%b exp=0", we_a_seen); end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_wrap();
    test_len_errors();
    test_forward_overlap();
    test_reset_mid_copy();
    test_start_held();
    test_we_a_tied();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_block_copy.md
Name: ram_block_copy

Overview:
- DMA-style initiator that drives both ports of the team's 64x8 dual-port synchronous RAM to copy a block of bytes inside that RAM.
- Port A is used read-only (source); port B is used write-only (destination).
- Sits between a control FSM/host register block and the RAM instance.
- Streams one byte per cycle after a 2-cycle pipeline fill.

Parameters:
- AW, 6, RAM address width (depth 2^AW = 64)
- DW, 8, RAM data width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request pulse, sampled only in IDLE
- src_addr  input  AW  first source address
- dst_addr  input  AW  first destination address
- len  input  AW+1  byte count, legal 1..64
- busy  output  1  high while a copy is in progress
- done  output  1  one-cycle pulse when the last write has been issued
- err  output  1  one-cycle pulse when a request is rejected
- ram_adrs_a  output  AW  RAM port A address
- ram_we_a  output  1  RAM port A write enable, constant 0
- ram_q_a  input  DW  RAM port A registered read data (1-cycle latency)
- ram_adrs_b  output  AW  RAM port B address
- ram_we_b  output  1  RAM port B write enable
- ram_d_b  output  DW  RAM port B write data

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: busy=0, done=0, err=0, ram_we_b=0, ram_adrs_a=0, ram_adrs_b=0, state=IDLE.
- ram_we_a is tied 0 at all times.
- States: IDLE, FILL, STREAM, FIN.
- IDLE: when start=1, request is latched at edge T. A request is rejected (err=1 at T+1, stays IDLE, no RAM access) if:
  - len=0, or
  - len>64, or
  - it is a forward overlap, i.e. (dst_addr-src_addr) mod 64 lies in 1..len-1 (macro-dependent, see Optional Feature).
- Otherwise go to FILL.
- FILL (cycle T+1):
  - busy=1.
  - ram_adrs_a = first read address.
  - No write.
- STREAM (cycles T+2 .. T+1+len):
  - In cycle T+2+k: ram_we_b=1, ram_adrs_b = k-th destination address, ram_d_b = ram_q_a (combinational pass-through of the RAM's registered output).
  - ram_adrs_a advances to the (k+1)-th source address while reads remain.
- FIN (cycle T+2+len):
  - done=1 for exactly one cycle.
  - busy=0 in the same cycle.
  - Return to IDLE.
  - A start in this cycle is ignored; the next accepted start is at T+3+len.
- Totals: len writes; latency start to done = len+2 cycles.
- Addresses wrap modulo 64 (AW-bit arithmetic). Example: src=62, len=4 reads 62,63,0,1.
- A start while busy=1 is ignored: no err, request not queued.
- rst mid-copy: the abort takes effect on the same edge. ram_we_b is 0 from the next cycle; no further writes are issued; bytes already written remain in the RAM.
- Read/write same-address collision: with ascending order and the one-cycle read lead, a non-rejected request never reads an address already overwritten by the same copy.
- Outputs other than ram_d_b are registered.

Optional Feature:
- Macro: RAM_BLOCK_COPY_OVERLAP_EN
- Defined: a forward-overlap request is accepted and executed as a descending copy.
  - Reads src+len-1 down to src; writes dst+len-1 down to dst (mod 64).
  - Timing is identical to the ascending copy. err is raised only for len=0 or len>64.
  - Non-overlapping and backward-overlap requests still copy ascending.
- Not defined: forward-overlap requests are rejected with an err pulse.

Test Plan:
- Preload RAM[0..7]=0x10..0x17; start src=0, dst=32, len=8:
  - busy=1 from T+1;
  - writes at T+2..T+9 put RAM[32..39]=0x10..0x17;
  - done pulse at T+10;
  - RAM[0..7] unchanged.
- Wrap: RAM[62]=0xA0, RAM[63]=0xA1, RAM[0]=0xA2; start src=62, dst=10, len=3 -> RAM[10..12]=0xA0,0xA1,0xA2; done at T+5.
- Errors:
  - start with len=0 -> err=1 at T+1; busy stays 0; ram_we_b never asserted.
  - start with len=65 -> same response.
- Forward overlap: RAM[0..3]=1,2,3,4; start src=0, dst=2, len=4.
  - Macro off -> err pulse, RAM unchanged.
  - Macro on -> RAM[2..5]=1,2,3,4.
- Reset mid-copy: start src=0, dst=40, len=16; assert rst at T+5 for one cycle -> busy=0, done=0, ram_we_b=0 after that edge; RAM[40..42] written; RAM[43..55] untouched.
- start held high through a full copy with len=2 -> exactly one copy; next copy accepted at T+5; no err while busy.
